// File: rtl/spi_rdid_responder.sv
// spi_rdid_responder: mode-0 SPI slave answering RDID (0x9F) with a repeating 24-bit JEDEC ID
//   clk        system clock; SPICLK/SPIMOSI/SPICS_N are oversampled in this domain
//   reset      asynchronous, active-low
//   SPICLK     SPI clock from master (idle low)
//   SPIMOSI    master-out data, sampled on SPICLK rise
//   SPICS_N    active-low chip select; high aborts/frames a transaction
//   SPIMISO    slave-out data, updated on SPICLK fall; 0 outside the ID phase
//   cmd_byte   last fully received opcode
//   cmd_valid  1-clk pulse when cmd_byte updates
//   rdid_done  1-clk pulse after each complete 24-bit ID
//   busy       registered, high while synchronized SPICS_N is low
module spi_rdid_responder #(
  parameter logic [23:0] JEDEC_ID    = 24'h202015,
  parameter logic [7:0]  CMD_RDID    = 8'h9F,
  parameter int          SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SPICLK,
  input  logic       SPIMOSI,
  input  logic       SPICS_N,
  output logic       SPIMISO,
  output logic [7:0] cmd_byte,
  output logic       cmd_valid,
  output logic       rdid_done,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, CMD, ID_OUT, IGNORE} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, mosi_sync_q, mosi_sync_d, csn_sync_q, csn_sync_d;
  logic        sclk_prev_q, sclk_prev_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [7:0]  cmd_sr_q, cmd_sr_d, cmd_byte_q, cmd_byte_d;
  logic [23:0] id_sr_q, id_sr_d;
  logic        miso_q, miso_d, cmd_valid_q, cmd_valid_d, rdid_done_q, rdid_done_d, busy_q, busy_d;
  logic        sclk_s, mosi_s, csn_s, rise, fall;
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign csn_s  = csn_sync_q[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_prev_q;
  assign fall   = ~sclk_s & sclk_prev_q;
  assign SPIMISO   = miso_q;
  assign cmd_byte  = cmd_byte_q;
  assign cmd_valid = cmd_valid_q;
  assign rdid_done = rdid_done_q;
  assign busy      = busy_q;
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SPICLK};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], SPIMOSI};
    csn_sync_d  = {csn_sync_q[SYNC_STAGES-2:0], SPICS_N};
    sclk_prev_d = sclk_s;
    busy_d      = ~csn_s;
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_sr_d    = cmd_sr_q;
    id_sr_d     = id_sr_q;
    miso_d      = miso_q;
    cmd_byte_d  = cmd_byte_q;
    cmd_valid_d = 1'b0;
    rdid_done_d = 1'b0;
    // Deselect overrides any SPICLK edge seen in the same cycle.
    if (csn_s) begin
      state_d = IDLE;
      miso_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = CMD;
          cnt_d    = 5'd0;
          cmd_sr_d = 8'h00;
          miso_d   = 1'b0;
        end
        CMD: if (rise) begin
          cmd_sr_d = {cmd_sr_q[6:0], mosi_s};
          cnt_d    = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            cmd_byte_d  = cmd_sr_d;
            cmd_valid_d = 1'b1;
            cnt_d       = 5'd0;
            id_sr_d     = JEDEC_ID;
            state_d     = (cmd_sr_d == CMD_RDID) ? ID_OUT : IGNORE;
          end
        end
        ID_OUT: if (fall) begin
          miso_d  = id_sr_q[23];
          id_sr_d = {id_sr_q[22:0], 1'b0};
          cnt_d   = cnt_q + 5'd1;
          // Reload so the ID repeats for as long as the master keeps clocking.
          if (cnt_q == 5'd23) begin
            rdid_done_d = 1'b1;
            id_sr_d     = JEDEC_ID;
            cnt_d       = 5'd0;
          end
        end
        IGNORE: miso_d = 1'b0;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      csn_sync_q  <= '1;
      sclk_prev_q <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      cmd_sr_q    <= 8'h00;
      id_sr_q     <= 24'h0;
      miso_q      <= 1'b0;
      cmd_byte_q  <= 8'h00;
      cmd_valid_q <= 1'b0;
      rdid_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      csn_sync_q  <= csn_sync_d;
      sclk_prev_q <= sclk_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_sr_q    <= cmd_sr_d;
      id_sr_q     <= id_sr_d;
      miso_q      <= miso_d;
      cmd_byte_q  <= cmd_byte_d;
      cmd_valid_q <= cmd_valid_d;
      rdid_done_q <= rdid_done_d;
      busy_q      <= busy_d;
    end
  end
endmodule

// File: tb/tb_spi_rdid_responder.sv
// tb_spi_rdid_responder: directed and randomized RDID frames against a bit-stream reference model
module tb_spi_rdid_responder;
  localparam logic [23:0] ID = 24'h202015;
  localparam int HALF = 10;
  logic clk = 1'b0, reset = 1'b0, SPICLK = 1'b0, SPIMOSI = 1'b0, SPICS_N = 1'b1;
  logic SPIMISO, cmd_valid, rdid_done, busy;
  logic [7:0] cmd_byte;
  int n_assert = 0, n_fail = 0, n_cv = 0, n_rd = 0;
  logic [7:0] exp_cmd = 8'h00;
  spi_rdid_responder dut (
    .clk(clk), .reset(reset), .SPICLK(SPICLK), .SPIMOSI(SPIMOSI), .SPICS_N(SPICS_N),
    .SPIMISO(SPIMISO), .cmd_byte(cmd_byte), .cmd_valid(cmd_valid), .rdid_done(rdid_done), .busy(busy)
  );
  always #10 clk = ~clk;
  always @(negedge clk) begin
    if (cmd_valid) n_cv++;
    if (rdid_done) n_rd++;
  end
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  // One chip-select frame of nclk SPICLK cycles; opcode bits first, random MOSI after.
  // If rst_at >= 0, reset is pulsed asynchronously after that rise and the frame is abandoned.
  task automatic frame(input string tag, input logic [7:0] op, input int nclk, input int rst_at);
    logic [127:0] got, exp;
    int cv0, rd0, idf, exp_rd;
    logic busy_ok;
    got = '0; exp = '0; busy_ok = 1'b1;
    cv0 = n_cv; rd0 = n_rd;
    SPICS_N = 1'b0;
    for (int i = 0; i < nclk; i++) begin
      SPIMOSI = (i < 8) ? op[7-i] : 1'($urandom_range(0, 1));
      wait_clk(HALF);
      got = {got[126:0], SPIMISO};
      exp = {exp[126:0], (i >= 8 && op == 8'h9F) ? ID[23 - ((i - 8) % 24)] : 1'b0};
      if (busy !== 1'b1) busy_ok = 1'b0;
      SPICLK = 1'b1;
      if (i == rst_at) begin
        wait_clk(HALF / 2);
        #3 reset = 1'b0;
        #1;
        check({tag, " rst miso"}, 128'(SPIMISO), 128'(0));
        check({tag, " rst cmd_byte"}, 128'(cmd_byte), 128'(0));
        check({tag, " rst cmd_valid"}, 128'(cmd_valid), 128'(0));
        check({tag, " rst rdid_done"}, 128'(rdid_done), 128'(0));
        check({tag, " rst busy"}, 128'(busy), 128'(0));
        check({tag, " miso before rst"}, got, exp);
        exp_cmd = 8'h00;
        SPICS_N = 1'b1; SPICLK = 1'b0; SPIMOSI = 1'b0;
        wait_clk(4);
        reset = 1'b1;
        wait_clk(HALF);
        return;
      end
      wait_clk(HALF);
      SPICLK = 1'b0;
    end
    wait_clk(HALF);
    SPICS_N = 1'b1;
    wait_clk(HALF);
    if (nclk >= 8) exp_cmd = op;
    idf = (nclk >= 8) ? nclk - 7 : 0;
    exp_rd = (op == 8'h9F) ? idf / 24 : 0;
    check({tag, " miso stream"}, got, exp);
    check({tag, " cmd_valid count"}, 128'(n_cv - cv0), 128'((nclk >= 8) ? 1 : 0));
    check({tag, " rdid_done count"}, 128'(n_rd - rd0), 128'(exp_rd));
    check({tag, " cmd_byte"}, 128'(cmd_byte), 128'(exp_cmd));
    check({tag, " busy in frame"}, 128'(busy_ok), 128'(1));
    check({tag, " idle miso"}, 128'(SPIMISO), 128'(0));
    check({tag, " idle busy"}, 128'(busy), 128'(0));
  endtask
  initial begin
    logic [7:0] op;
    int n;
    wait_clk(3);
    check("reset miso", 128'(SPIMISO), 128'(0));
    check("reset cmd_byte", 128'(cmd_byte), 128'(0));
    check("reset cmd_valid", 128'(cmd_valid), 128'(0));
    check("reset rdid_done", 128'(rdid_done), 128'(0));
    check("reset busy", 128'(busy), 128'(0));
    reset = 1'b1;
    wait_clk(5);
    frame("rdid24", 8'h9F, 32, -1);
    frame("rdid48", 8'h9F, 56, -1);
    frame("op05", 8'h05, 24, -1);
    frame("abort5", 8'h9F, 5, -1);
    frame("after_abort", 8'h9F, 32, -1);
    frame("rst_mid_id", 8'h9F, 32, 17);
    frame("after_rst", 8'h9F, 32, -1);
    frame("short_id", 8'h9F, 20, -1);
    for (int k = 0; k < 8; k++) begin
      op = ($urandom_range(0, 1) == 1) ? 8'h9F : 8'($urandom);
      n = $urandom_range(3, 64);
      frame("rand", op, n, -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
